// File: rtl/fse_pkg.sv
// fse_pkg: formats, reset taps and FSM states shared by the equalizer and its LMS engine
package fse_pkg;
    localparam int NUM_TAPS = 9;
    localparam int NBT_IN = 8;
    localparam int NBF_IN = 7;
    localparam int NBT_ERR = 12;
    localparam int NBF_ERR = 9;
    localparam int NBT_TAPS = 28;
    localparam int NBF_TAPS = 25;
    localparam int MU_SHIFT_DEF = 9;
    localparam int ALIGN_DEF = 2;
    localparam int MID_IDX = NUM_TAPS / 2;
    localparam logic signed [NBT_TAPS-1:0] TAP_ONE = NBT_TAPS'(1 << NBF_TAPS);
    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_COMMIT} lms_state_t;
    // Centre I tap starts at 1.0 so the equalizer powers up as a pass-through.
    function automatic logic signed [NBT_TAPS-1:0] reset_tap_i(input int j);
        return (j == MID_IDX) ? TAP_ONE : '0;
    endfunction
endpackage

// File: rtl/lms_cmac.sv
// lms_cmac: one complex LMS step, w + 2^-MU * e * conj(x), saturated to the tap format
//   i_e_i/i_e_q : error S(NBT_ERR,NBF_ERR)
//   i_x_i/i_x_q : window sample S(NBT_IN,NBF_IN)
//   i_w_i/i_w_q : current tap S(NBT_TAPS,NBF_TAPS)
//   o_w_i/o_w_q : updated tap, same format
module lms_cmac
    import fse_pkg::*;
#(
    parameter int MU_SHIFT = MU_SHIFT_DEF
) (
    input  logic signed [NBT_ERR-1:0]  i_e_i,
    input  logic signed [NBT_ERR-1:0]  i_e_q,
    input  logic signed [NBT_IN-1:0]   i_x_i,
    input  logic signed [NBT_IN-1:0]   i_x_q,
    input  logic signed [NBT_TAPS-1:0] i_w_i,
    input  logic signed [NBT_TAPS-1:0] i_w_q,
    output logic signed [NBT_TAPS-1:0] o_w_i,
    output logic signed [NBT_TAPS-1:0] o_w_q
);
    localparam int PW = NBT_ERR + NBT_IN + 1;
    localparam int SH = NBF_TAPS - NBF_ERR - NBF_IN - MU_SHIFT;
    // Wide enough for any left alignment plus the tap, so nothing wraps before saturation.
    localparam int AW = PW + NBT_TAPS + 2;
    localparam logic signed [NBT_TAPS-1:0] MAX_T = {1'b0, {(NBT_TAPS-1){1'b1}}};
    localparam logic signed [NBT_TAPS-1:0] MIN_T = {1'b1, {(NBT_TAPS-1){1'b0}}};
    localparam logic signed [AW-1:0] MAX_A = AW'(MAX_T);
    localparam logic signed [AW-1:0] MIN_A = AW'(MIN_T);

    logic signed [PW-2:0] p_ii, p_qq, p_qi, p_iq;
    logic signed [PW-1:0] re, im;
    logic signed [AW-1:0] re_a, im_a, acc_i, acc_q;

    function automatic logic signed [NBT_TAPS-1:0] sat(input logic signed [AW-1:0] v);
        return (v > MAX_A) ? MAX_T : (v < MIN_A) ? MIN_T : v[NBT_TAPS-1:0];
    endfunction

    always_comb begin
        p_ii = (PW-1)'(i_e_i) * (PW-1)'(i_x_i);
        p_qq = (PW-1)'(i_e_q) * (PW-1)'(i_x_q);
        p_qi = (PW-1)'(i_e_q) * (PW-1)'(i_x_i);
        p_iq = (PW-1)'(i_e_i) * (PW-1)'(i_x_q);
        re = PW'(p_ii) + PW'(p_qq);
        im = PW'(p_qi) - PW'(p_iq);
    end

    if (SH >= 0) begin : g_shl
        assign re_a = AW'(re) <<< SH;
        assign im_a = AW'(im) <<< SH;
    end else begin : g_shr
        assign re_a = AW'(re) >>> (-SH);
        assign im_a = AW'(im) >>> (-SH);
    end

    always_comb begin
        acc_i = AW'(i_w_i) + re_a;
        acc_q = AW'(i_w_q) + im_a;
        o_w_i = sat(acc_i);
        o_w_q = sat(acc_q);
    end
endmodule

// File: rtl/lms_tap_update.sv
// lms_tap_update: serial complex LMS coefficient engine, one tap per cycle, for the FSE
//   clk, i_reset               : clock, synchronous active-high reset
//   i_is_data_I/Q, i_ctrl      : equalizer input stream and its rate-2 shift enable
//   i_err_I/Q, i_err_valid     : slicer error and qualifier
//   i_enable                   : adaptation enable
//   o_taps_I/Q, o_en_taps      : packed tap bank and its one-cycle load strobe
//   o_busy, o_overrun          : update in progress, sticky dropped-error flag
module lms_tap_update
    import fse_pkg::*;
#(
    parameter int MU_SHIFT = MU_SHIFT_DEF,
    parameter int ALIGN = ALIGN_DEF
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic [NBT_IN-1:0]            i_is_data_I,
    input  logic [NBT_IN-1:0]            i_is_data_Q,
    input  logic                         i_ctrl,
    input  logic [NBT_ERR-1:0]           i_err_I,
    input  logic [NBT_ERR-1:0]           i_err_Q,
    input  logic                         i_err_valid,
    input  logic                         i_enable,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
    output logic                         o_en_taps,
    output logic                         o_busy,
    output logic                         o_overrun
);
    localparam int DL = NUM_TAPS + ALIGN;
    localparam int KW = $clog2(NUM_TAPS);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_TAPS - 1);

    lms_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic signed [NBT_IN-1:0] dli_q [DL], dli_d [DL], dlq_q [DL], dlq_d [DL];
    logic signed [NBT_IN-1:0] xi_q [NUM_TAPS], xi_d [NUM_TAPS], xq_q [NUM_TAPS], xq_d [NUM_TAPS];
    logic signed [NBT_ERR-1:0] ei_q, ei_d, eq_q, eq_d;
    logic signed [NBT_TAPS-1:0] wi_q [NUM_TAPS], wi_d [NUM_TAPS], wq_q [NUM_TAPS], wq_d [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] ti_q [NUM_TAPS], ti_d [NUM_TAPS], tq_q [NUM_TAPS], tq_d [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] wi_new, wq_new;
    logic en_q, en_d, busy_q, busy_d, ovr_q, ovr_d;
    logic err_acc;

    lms_cmac #(.MU_SHIFT(MU_SHIFT)) u_cmac (
        .i_e_i (ei_q),
        .i_e_q (eq_q),
        .i_x_i (xi_q[k_q]),
        .i_x_q (xq_q[k_q]),
        .i_w_i (wi_q[k_q]),
        .i_w_q (wq_q[k_q]),
        .o_w_i (wi_new),
        .o_w_q (wq_new)
    );

    assign err_acc = i_err_valid && i_enable;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        dli_d = dli_q;
        dlq_d = dlq_q;
        xi_d = xi_q;
        xq_d = xq_q;
        ei_d = ei_q;
        eq_d = eq_q;
        wi_d = wi_q;
        wq_d = wq_q;
        ti_d = ti_q;
        tq_d = tq_q;
        en_d = 1'b0;
        ovr_d = ovr_q || (err_acc && state_q != ST_IDLE);
        if (i_ctrl) begin
            dli_d[0] = i_is_data_I;
            dlq_d[0] = i_is_data_Q;
            for (int n = 1; n < DL; n++) begin
                dli_d[n] = dli_q[n-1];
                dlq_d[n] = dlq_q[n-1];
            end
        end
        case (state_q)
            ST_IDLE: if (err_acc) begin
                ei_d = i_err_I;
                eq_d = i_err_Q;
                // Window taken from the pre-edge line so a same-cycle shift is not seen.
                for (int j = 0; j < NUM_TAPS; j++) begin
                    xi_d[j] = dli_q[j+ALIGN];
                    xq_d[j] = dlq_q[j+ALIGN];
                end
                k_d = '0;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                wi_d[k_q] = wi_new;
                wq_d[k_q] = wq_new;
                k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
                state_d = (k_q == K_LAST) ? ST_COMMIT : ST_UPDATE;
            end
            ST_COMMIT: begin
                ti_d = wi_q;
                tq_d = wq_q;
                en_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            k_q <= '0;
            ei_q <= '0;
            eq_q <= '0;
            for (int n = 0; n < DL; n++) begin
                dli_q[n] <= '0;
                dlq_q[n] <= '0;
            end
            for (int j = 0; j < NUM_TAPS; j++) begin
                xi_q[j] <= '0;
                xq_q[j] <= '0;
                wi_q[j] <= reset_tap_i(j);
                wq_q[j] <= '0;
                ti_q[j] <= reset_tap_i(j);
                tq_q[j] <= '0;
            end
            en_q <= 1'b0;
            busy_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            ei_q <= ei_d;
            eq_q <= eq_d;
            dli_q <= dli_d;
            dlq_q <= dlq_d;
            xi_q <= xi_d;
            xq_q <= xq_d;
            wi_q <= wi_d;
            wq_q <= wq_d;
            ti_q <= ti_d;
            tq_q <= tq_d;
            en_q <= en_d;
            busy_q <= busy_d;
            ovr_q <= ovr_d;
        end
    end

    for (genvar j = 0; j < NUM_TAPS; j++) begin : g_pack
        assign o_taps_I[j*NBT_TAPS +: NBT_TAPS] = ti_q[j];
        assign o_taps_Q[j*NBT_TAPS +: NBT_TAPS] = tq_q[j];
    end

    assign o_en_taps = en_q;
    assign o_busy = busy_q;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_lms_tap_update.sv
// tb_lms_tap_update: scoreboard bench for the LMS engine at default and unit step size
module tb_lms_tap_update;
    import fse_pkg::*;
    localparam int W = NUM_TAPS * NBT_TAPS;
    localparam int DL = NUM_TAPS + ALIGN_DEF;

    typedef struct {
        logic [W-1:0] ti;
        logic [W-1:0] tq;
        int at;
        int d;
    } exp_t;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic [NBT_IN-1:0] d_i = '0, d_q = '0;
    logic ctrl = 1'b0, ev = 1'b0, ev2 = 1'b0, ena = 1'b1;
    logic [NBT_ERR-1:0] e_i = '0, e_q = '0;
    logic [W-1:0] t_i [2], t_q [2];
    logic o_en [2], busy [2], ovr [2];

    int total = 0, bad = 0, ncyc = 0;
    longint mdi [DL], mdq [DL];
    longint mwi [2][NUM_TAPS], mwq [2][NUM_TAPS];
    int mcnt [2];
    bit movr [2];
    exp_t sb [$];
    logic [W-1:0] rst_i;

    always #5 clk = ~clk;

    lms_tap_update u_dut (
        .clk(clk), .i_reset(i_reset), .i_is_data_I(d_i), .i_is_data_Q(d_q), .i_ctrl(ctrl),
        .i_err_I(e_i), .i_err_Q(e_q), .i_err_valid(ev), .i_enable(ena),
        .o_taps_I(t_i[0]), .o_taps_Q(t_q[0]), .o_en_taps(o_en[0]), .o_busy(busy[0]), .o_overrun(ovr[0])
    );

    lms_tap_update #(.MU_SHIFT(0)) u_sat (
        .clk(clk), .i_reset(i_reset), .i_is_data_I(d_i), .i_is_data_Q(d_q), .i_ctrl(ctrl),
        .i_err_I(e_i), .i_err_Q(e_q), .i_err_valid(ev2), .i_enable(ena),
        .o_taps_I(t_i[1]), .o_taps_Q(t_q[1]), .o_en_taps(o_en[1]), .o_busy(busy[1]), .o_overrun(ovr[1])
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        longint lim = 64'sd1 <<< (NBT_TAPS - 1);
        return (v > lim - 1) ? lim - 1 : (v < -lim) ? -lim : v;
    endfunction

    task automatic accept(input int d);
        exp_t x;
        longint ei, eq, xi, xq, re, im;
        logic [63:0] b;
        int sh = NBF_TAPS - NBF_ERR - NBF_IN - (d == 0 ? MU_SHIFT_DEF : 0);
        ei = longint'($signed(e_i));
        eq = longint'($signed(e_q));
        for (int k = 0; k < NUM_TAPS; k++) begin
            xi = mdi[k+ALIGN_DEF];
            xq = mdq[k+ALIGN_DEF];
            re = ei * xi + eq * xq;
            im = eq * xi - ei * xq;
            mwi[d][k] = clamp(mwi[d][k] + (sh >= 0 ? re <<< sh : re >>> (-sh)));
            mwq[d][k] = clamp(mwq[d][k] + (sh >= 0 ? im <<< sh : im >>> (-sh)));
            b = mwi[d][k];
            x.ti[k*NBT_TAPS +: NBT_TAPS] = b[NBT_TAPS-1:0];
            b = mwq[d][k];
            x.tq[k*NBT_TAPS +: NBT_TAPS] = b[NBT_TAPS-1:0];
        end
        x.at = ncyc + NUM_TAPS + 1;
        x.d = d;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin : model_p
        bit acc;
        ncyc++;
        if (i_reset) begin
            for (int n = 0; n < DL; n++) begin
                mdi[n] = 0;
                mdq[n] = 0;
            end
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    mwi[d][k] = (k == MID_IDX) ? (64'sd1 <<< NBF_TAPS) : 0;
                    mwq[d][k] = 0;
                end
                mcnt[d] = 0;
                movr[d] = 0;
            end
            sb.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                acc = ena && (d == 0 ? ev : ev2);
                if (mcnt[d] != 0) begin
                    if (acc) movr[d] = 1;
                    mcnt[d]--;
                end else if (acc) begin
                    accept(d);
                    mcnt[d] = NUM_TAPS + 1;
                end
            end
            if (ctrl) begin
                for (int n = DL - 1; n > 0; n--) begin
                    mdi[n] = mdi[n-1];
                    mdq[n] = mdq[n-1];
                end
                mdi[0] = longint'($signed(d_i));
                mdq[0] = longint'($signed(d_q));
            end
        end
    end

    always @(negedge clk) begin : mon_p
        int idx;
        if (!i_reset) begin
            for (int d = 0; d < 2; d++) begin
                if (o_en[d]) begin
                    idx = -1;
                    for (int n = 0; n < sb.size(); n++) if (sb[n].d == d && idx < 0) idx = n;
                    if (idx < 0) chk("spurious_en", W'(o_en[d]), '0);
                    else begin
                        chk("taps_i", t_i[d], sb[idx].ti);
                        chk("taps_q", t_q[d], sb[idx].tq);
                        chk("en_time", W'(ncyc), W'(sb[idx].at));
                        sb.delete(idx);
                    end
                end
                chk("ovr_trk", W'(ovr[d]), W'(movr[d]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int xi, input int xq);
        d_i = NBT_IN'(xi);
        d_q = NBT_IN'(xq);
        ctrl = 1'b1;
        @(negedge clk);
        ctrl = 1'b0;
    endtask

    task automatic load_one(input int k, input int xi, input int xq);
        for (int p = NUM_TAPS - 1; p >= 0; p--) push(p == k ? xi : 0, p == k ? xq : 0);
        repeat (ALIGN_DEF) push(0, 0);
    endtask

    task automatic fire(input int d, input int ei, input int eq);
        e_i = NBT_ERR'(ei);
        e_q = NBT_ERR'(eq);
        if (d == 0) ev = 1'b1;
        else ev2 = 1'b1;
        @(negedge clk);
        ev = 1'b0;
        ev2 = 1'b0;
    endtask

    task automatic wait_en(input int d);
        int n = 0;
        while (!o_en[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("en_seen", W'(o_en[d]), W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = '0;
        rst_i[MID_IDX*NBT_TAPS +: NBT_TAPS] = 28'h2000000;
        tick(3);
        chk("rst_taps_i", t_i[0], rst_i);
        chk("rst_taps_q", t_q[0], '0);
        chk("rst_sat_taps_i", t_i[1], rst_i);
        chk("rst_en", W'(o_en[0]), '0);
        chk("rst_busy", W'(busy[0]), '0);
        chk("rst_ovr", W'(ovr[0]), '0);
        i_reset = 1'b0;
        tick(2);

        load_one(4, 64, 0);
        fire(0, 256, 0);
        tick(2);
        chk("busy_mid", W'(busy[0]), W'(1));
        wait_en(0);
        chk("real_tap4_i", W'(t_i[0][4*NBT_TAPS +: NBT_TAPS]), W'(28'h2004000));
        chk("real_q", t_q[0], '0);
        tick(2);

        load_one(0, 0, 64);
        fire(0, 256, 0);
        wait_en(0);
        chk("cross_tap0_q", W'(t_q[0][0 +: NBT_TAPS]), W'(28'hFFFC000));
        chk("cross_tap0_i", W'(t_i[0][0 +: NBT_TAPS]), '0);
        chk("cross_tap4_i", W'(t_i[0][4*NBT_TAPS +: NBT_TAPS]), W'(28'h2004000));
        tick(2);

        load_one(4, -128, 0);
        fire(1, -2048, 0);
        wait_en(1);
        chk("sat_tap4_i", W'(t_i[1][4*NBT_TAPS +: NBT_TAPS]), W'(28'h7FFFFFF));
        tick(2);

        ena = 1'b0;
        fire(0, 100, 20);
        tick(14);
        chk("dis_no_ovr", W'(ovr[0]), '0);
        ena = 1'b1;
        load_one(2, 30, -40);
        e_i = NBT_ERR'(77);
        e_q = NBT_ERR'(-33);
        ev = 1'b1;
        tick(2);
        ev = 1'b0;
        wait_en(0);
        chk("ovr_set", W'(ovr[0]), W'(1));
        tick(2);
        ena = 1'b0;
        fire(0, 5, 5);
        tick(13);
        chk("ovr_hold", W'(ovr[0]), W'(1));
        ena = 1'b1;

        load_one(1, 50, 50);
        fire(0, 300, -200);
        tick(3);
        chk("busy_k3", W'(busy[0]), W'(1));
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        chk("abort_busy", W'(busy[0]), '0);
        chk("abort_taps_i", t_i[0], rst_i);
        chk("abort_taps_q", t_q[0], '0);
        chk("abort_ovr", W'(ovr[0]), '0);
        tick(15);

        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(11, 14)) push($urandom_range(0, 255), $urandom_range(0, 255));
            fire(0, $urandom_range(0, 4095), $urandom_range(0, 4095));
            repeat (12) begin
                ctrl = 1'($urandom_range(0, 1));
                d_i = NBT_IN'($urandom_range(0, 255));
                d_q = NBT_IN'($urandom_range(0, 255));
                @(negedge clk);
            end
            ctrl = 1'b0;
        end
        tick(20);
        chk("sb_empty", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
